// File: rtl/artemis_gtp_pkg.sv
// Shared state codes and counter sizing for the GTP link bring-up controller.
package artemis_gtp_pkg;

    localparam logic [2:0] ST_RESET     = 3'd0;
    localparam logic [2:0] ST_WAIT_PLL  = 3'd1;
    localparam logic [2:0] ST_WAIT_DONE = 3'd2;
    localparam logic [2:0] ST_ALIGN     = 3'd3;
    localparam logic [2:0] ST_LINKED    = 3'd4;

    // Bits needed to count 0 .. n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/artemis_gtp_link_ch.sv
// One transceiver channel: reset sequencing, lock/done wait, comma alignment and link supervision.
// Optional electrical-idle unlink is built when ARTEMIS_GTP_ELEC_IDLE_EN is defined.
module artemis_gtp_link_ch
    import artemis_gtp_pkg::*;
#(
    parameter int BYTES        = 4,
    parameter int RESET_CYCLES = 16,
    parameter int TIMEOUT      = 65536,
    parameter int ALIGN_COMMAS = 8,
    parameter int ERR_WINDOW   = 1024,
    parameter int ERR_THRESH   = 4,
    parameter int ERR_W        = 16,
    parameter int IDLE_CYCLES  = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_pll_detect_k,
    input  logic             i_reset_done,
    input  logic [BYTES-1:0] i_rx_char_is_comma,
    input  logic [BYTES-1:0] i_disparity_error,
    input  logic [BYTES-1:0] i_rx_not_in_table,
    input  logic             i_rx_elec_idle,
    output logic             o_gtp_reset,
    output logic             o_rx_reset,
    output logic             o_link_up,
    output logic [2:0]       o_state,
    output logic [ERR_W-1:0] o_err_count
);

    // The reset-length count shares the timeout counter, so size it for the larger of the two.
    localparam int TW = cnt_w((TIMEOUT > RESET_CYCLES) ? TIMEOUT : RESET_CYCLES);
    localparam int CW = cnt_w(ALIGN_COMMAS);
    localparam int WW = cnt_w(ERR_WINDOW);
    localparam int EW = cnt_w(ERR_THRESH);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] RST_LAST   = TW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] COMMA_LAST = CW'(ALIGN_COMMAS - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(ERR_WINDOW - 1);
    localparam logic [EW-1:0] THR_LAST   = EW'(ERR_THRESH - 1);

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [CW-1:0]    comma_cnt_q, comma_cnt_d;
    logic [WW-1:0]    win_cnt_q, win_cnt_d;
    logic [EW-1:0]    win_err_q, win_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             gtp_reset_q, gtp_reset_d;
    logic             rx_reset_q, rx_reset_d;
    logic             link_q, link_d;

    logic code_err, comma_word, tmo_last, idle_hit;

    assign code_err   = |(i_disparity_error | i_rx_not_in_table);
    assign comma_word = (|i_rx_char_is_comma) && !code_err;
    assign tmo_last   = (tmo_cnt_q == TMO_LAST);

`ifdef ARTEMIS_GTP_ELEC_IDLE_EN
    localparam int IW = cnt_w(IDLE_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;

    assign idle_hit = i_rx_elec_idle && (idle_cnt_q == IDLE_LAST);

    always_comb begin
        idle_cnt_d = '0;
        if (state_q == ST_LINKED && state_d == ST_LINKED && i_rx_elec_idle)
            idle_cnt_d = idle_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) idle_cnt_q <= '0;
        else     idle_cnt_q <= idle_cnt_d;
    end
`else
    logic unused_idle;
    assign idle_hit    = 1'b0;
    assign unused_idle = i_rx_elec_idle ^ (IDLE_CYCLES != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RESET;
            tmo_cnt_q   <= '0;
            comma_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_cnt_q   <= '0;
            gtp_reset_q <= 1'b1;
            rx_reset_q  <= 1'b0;
            link_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_cnt_q   <= err_cnt_d;
            gtp_reset_q <= gtp_reset_d;
            rx_reset_q  <= rx_reset_d;
            link_q      <= link_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q + 1'b1;
        comma_cnt_d = comma_cnt_q;
        win_cnt_d   = '0;
        win_err_d   = '0;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            ST_RESET: begin
                if (tmo_cnt_q == RST_LAST) state_d = ST_WAIT_PLL;
            end
            ST_WAIT_PLL: begin
                if (tmo_last)            state_d = ST_RESET;
                else if (i_pll_detect_k) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!i_pll_detect_k || tmo_last) state_d = ST_RESET;
                else if (i_reset_done)           state_d = ST_ALIGN;
            end
            ST_ALIGN: begin
                if (!i_pll_detect_k) begin
                    state_d = ST_RESET;
                end else if (tmo_last) begin
                    // Stay put and retry with a fresh RX datapath reset.
                    tmo_cnt_d   = '0;
                    comma_cnt_d = '0;
                end else if (comma_word) begin
                    if (comma_cnt_q == COMMA_LAST) state_d = ST_LINKED;
                    else                           comma_cnt_d = comma_cnt_q + 1'b1;
                end else if (code_err) begin
                    comma_cnt_d = '0;
                end
            end
            ST_LINKED: begin
                tmo_cnt_d = '0;
                win_cnt_d = (win_cnt_q == WIN_LAST) ? '0 : win_cnt_q + 1'b1;
                win_err_d = (win_cnt_q == WIN_LAST) ? '0 : win_err_q + EW'(code_err);
                if (code_err && err_cnt_q != {ERR_W{1'b1}})
                    err_cnt_d = err_cnt_q + 1'b1;
                if (!i_pll_detect_k)
                    state_d = ST_RESET;
                else if ((code_err && win_err_q == THR_LAST) || idle_hit)
                    state_d = ST_ALIGN;
            end
            default: state_d = ST_RESET;
        endcase

        if (!i_enable) begin
            state_d   = ST_RESET;
            tmo_cnt_d = '0;
        end
        if (state_d != state_q) tmo_cnt_d = '0;
        if (state_d == ST_ALIGN && state_q != ST_ALIGN) comma_cnt_d = '0;
        if (state_d != ST_LINKED) begin
            win_cnt_d = '0;
            win_err_d = '0;
        end
    end

    always_comb begin
        gtp_reset_d = (state_d == ST_RESET);
        link_d      = (state_q == ST_LINKED);
        rx_reset_d  = (state_d == ST_ALIGN) && ((state_q != ST_ALIGN) || tmo_last);
    end

    assign o_gtp_reset = gtp_reset_q;
    assign o_rx_reset  = rx_reset_q;
    assign o_link_up   = link_q;
    assign o_state     = state_q;
    assign o_err_count = err_cnt_q;

endmodule

// File: rtl/artemis_gtp_link_init.sv
// Multi-channel GTP bring-up and link supervision; one independent controller per channel.
// Optional electrical-idle unlink is built when ARTEMIS_GTP_ELEC_IDLE_EN is defined.
module artemis_gtp_link_init
    import artemis_gtp_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int BYTES        = 4,
    parameter int RESET_CYCLES = 16,
    parameter int TIMEOUT      = 65536,
    parameter int ALIGN_COMMAS = 8,
    parameter int ERR_WINDOW   = 1024,
    parameter int ERR_THRESH   = 4,
    parameter int ERR_W        = 16,
    parameter int IDLE_CYCLES  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       i_enable,
    input  logic [NUM_CH-1:0]       i_pll_detect_k,
    input  logic [NUM_CH-1:0]       i_reset_done,
    input  logic [NUM_CH*BYTES-1:0] i_rx_char_is_comma,
    input  logic [NUM_CH*BYTES-1:0] i_disparity_error,
    input  logic [NUM_CH*BYTES-1:0] i_rx_not_in_table,
    input  logic [NUM_CH-1:0]       i_rx_elec_idle,
    output logic [NUM_CH-1:0]       o_gtp_reset,
    output logic [NUM_CH-1:0]       o_rx_reset,
    output logic [NUM_CH-1:0]       o_link_up,
    output logic [NUM_CH*3-1:0]     o_state,
    output logic [NUM_CH*ERR_W-1:0] o_err_count
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        artemis_gtp_link_ch #(
            .BYTES        (BYTES),
            .RESET_CYCLES (RESET_CYCLES),
            .TIMEOUT      (TIMEOUT),
            .ALIGN_COMMAS (ALIGN_COMMAS),
            .ERR_WINDOW   (ERR_WINDOW),
            .ERR_THRESH   (ERR_THRESH),
            .ERR_W        (ERR_W),
            .IDLE_CYCLES  (IDLE_CYCLES)
        ) u_ch (
            .clk                (clk),
            .rst                (rst),
            .i_enable           (i_enable[g]),
            .i_pll_detect_k     (i_pll_detect_k[g]),
            .i_reset_done       (i_reset_done[g]),
            .i_rx_char_is_comma (i_rx_char_is_comma[g*BYTES +: BYTES]),
            .i_disparity_error  (i_disparity_error[g*BYTES +: BYTES]),
            .i_rx_not_in_table  (i_rx_not_in_table[g*BYTES +: BYTES]),
            .i_rx_elec_idle     (i_rx_elec_idle[g]),
            .o_gtp_reset        (o_gtp_reset[g]),
            .o_rx_reset         (o_rx_reset[g]),
            .o_link_up          (o_link_up[g]),
            .o_state            (o_state[g*3 +: 3]),
            .o_err_count        (o_err_count[g*ERR_W +: ERR_W])
        );
    end

endmodule
